// File: rtl/spi_clk_gen.sv
// SPI serial-clock divider and chip-select framer feeding the shift core.
// Sequences IDLE -> SETUP -> RUN -> HOLD -> GAP and emits SCK edge strobes.
module spi_clk_gen #(
    parameter int DIV_WIDTH = 16,
    parameter int CSD_WIDTH = 8,
    parameter int NSS_NUM   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 cpol_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [CSD_WIDTH-1:0] csd_i,
    input  logic [NSS_NUM-1:0]   nss_sel_i,
    input  logic                 start_i,
    input  logic                 last_i,
    output logic                 st_o,
    output logic                 busy_o,
    output logic                 pos_edge_o,
    output logic                 neg_edge_o,
    output logic                 sck_o,
    output logic [NSS_NUM-1:0]   nss_o,
    output logic                 done_o
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        HOLD,
        GAP
    } state_t;

    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_cnt_div;
    logic [CSD_WIDTH-1:0] r_cnt_csd;
    logic [DIV_WIDTH-1:0] r_div;
    logic [CSD_WIDTH-1:0] r_csd;
    logic                 r_cpol;
    logic                 r_sck;
    logic [NSS_NUM-1:0]   r_nss;
    logic                 r_st;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_bound;
    logic                 w_stop;
    logic                 w_edge;
    logic [NSS_NUM-1:0]   w_sel_low;

    // Isolate the lowest set select bit so only one NSS line can go low.
    assign w_sel_low = nss_sel_i & (~nss_sel_i + NSS_NUM'(1));

    assign w_bound = (r_state == RUN) && (r_cnt_div == r_div);
    assign w_stop  = w_bound && last_i && (r_sck == r_cpol);
    assign w_edge  = w_bound && !w_stop && en_i;

    assign pos_edge_o = w_edge && !r_sck;
    assign neg_edge_o = w_edge && r_sck;

    assign st_o   = r_st;
    assign busy_o = r_busy;
    assign sck_o  = r_sck;
    assign nss_o  = r_nss;
    assign done_o = r_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt_div <= '0;
            r_cnt_csd <= '0;
            r_div     <= '0;
            r_csd     <= '0;
            r_cpol    <= 1'b0;
            r_sck     <= 1'b0;
            r_nss     <= '1;
            r_st      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!en_i && r_state != IDLE) begin
                r_state   <= IDLE;
                r_sck     <= r_cpol;
                r_nss     <= '1;
                r_st      <= 1'b0;
                r_busy    <= 1'b0;
                r_cnt_div <= '0;
                r_cnt_csd <= '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_sck <= cpol_i;
                        r_nss <= '1;
                        if (en_i && start_i && (|nss_sel_i)) begin
                            r_cpol    <= cpol_i;
                            r_div     <= div_i;
                            r_csd     <= csd_i;
                            r_nss     <= ~w_sel_low;
                            r_busy    <= 1'b1;
                            r_cnt_csd <= '0;
                            r_state   <= SETUP;
                        end
                    end
                    SETUP: begin
                        if (r_cnt_csd == r_csd) begin
                            r_state   <= RUN;
                            r_cnt_csd <= '0;
                            r_cnt_div <= '0;
                            r_st      <= 1'b1;
                        end else begin
                            r_cnt_csd <= r_cnt_csd + CSD_WIDTH'(1);
                        end
                    end
                    RUN: begin
                        if (w_stop) begin
                            r_state   <= HOLD;
                            r_st      <= 1'b0;
                            r_cnt_div <= '0;
                        end else if (w_bound) begin
                            r_cnt_div <= '0;
                            r_sck     <= ~r_sck;
                        end else begin
                            r_cnt_div <= r_cnt_div + DIV_WIDTH'(1);
                        end
                    end
                    HOLD: begin
                        if (r_cnt_csd == r_csd) begin
                            r_state   <= GAP;
                            r_nss     <= '1;
                            r_cnt_csd <= '0;
                            r_done    <= (r_csd == '0);
                        end else begin
                            r_cnt_csd <= r_cnt_csd + CSD_WIDTH'(1);
                        end
                    end
                    GAP: begin
                        // done is registered, so it is raised entering the final GAP cycle
                        if (r_cnt_csd == r_csd) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt_csd <= r_cnt_csd + CSD_WIDTH'(1);
                            r_done    <= ((r_cnt_csd + CSD_WIDTH'(1)) == r_csd);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
